imem_arbiter: RTL and testbench

- Shares the single-ported 80-bit instruction memory between two requesters: the fetch stage (read only) and the program loader/debug port (read/write).
- Sits between fetch/loader and the instruction memory array. Issues at most one memory access per cycle; memory read latency is fixed at 1 cycle.
- Provides round-robin fairness, a loader lock for bulk program loads, out-of-range error responses and a fetch-stall counter.

---
 rtl/y86_mem_pkg.sv | 25 ++
 rtl/imem_arbiter_rr_arb2.sv | 45 ++++
 rtl/imem_arbiter.sv | 138 +++++++++++++
 tb/tb_imem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared types for the y86 instruction-memory path: widths, requester
// identity and the one-entry response record carried to the next cycle.
package y86_mem_pkg;

  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 80;

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   was_write;
    logic   oor;
  } resp_t;

  localparam resp_t RESP_IDLE = '{owner: OWN_LOADER, was_write: 1'b0, oor: 1'b0};

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_FETCH) ? OWN_LOADER : OWN_FETCH;
  endfunction

endpackage

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between fetch and loader. force_l hands the
// loader exclusive ownership; last_owner breaks ties toward the other side.
module rr_arb2
  import y86_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_f,
  input  logic req_l,
  input  logic force_l,
  output logic gnt_f,
  output logic gnt_l
);

  owner_e last_owner;
  owner_e favoured;

  assign favoured = other_owner(last_owner);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    gnt_f = 1'b0;
    gnt_l = 1'b0;
    if (req_f && !force_l && (!req_l || favoured == OWN_FETCH)) begin
      gnt_f = 1'b1;
    end else if (req_l) begin
      gnt_l = 1'b1;
    end
  end

  // Starting as if the loader went last lets fetch win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      last_owner <= OWN_LOADER;
    end else if (gnt_f) begin
      last_owner <= OWN_FETCH;
    end else if (gnt_l) begin
      last_owner <= OWN_LOADER;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-ported instruction memory between fetch and the loader:
// one access per cycle, 1-cycle read latency, range errors, stall counting.
module imem_arbiter
  import y86_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = 10,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,

  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,

  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,

  output logic [CNT_W-1:0]  f_stall_cnt
);

  logic              f_req_v;
  logic              l_req_v;
  logic              f_oor;
  logic              l_oor;
  logic              acc_oor;
  logic              resp_valid_q;
  resp_t             resp_q;
  resp_t             resp_d;
  logic [DATA_W-1:0] resp_data;
  logic [DATA_W-1:0] f_rdata_q;
  logic [DATA_W-1:0] l_rdata_q;

  // Grants are combinational, so requests are masked while reset is held to
  // keep gnt and the memory strobes at their reset values.
  assign f_req_v = f_req & rst_n;
  assign l_req_v = l_req & rst_n;

  assign f_oor = (f_addr >= ADDR_W'(DEPTH));
  assign l_oor = (l_addr >= ADDR_W'(DEPTH));

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_f   (f_req_v),
    .req_l   (l_req_v),
    .force_l (l_lock),
    .gnt_f   (f_gnt),
    .gnt_l   (l_gnt)
  );

  // An out-of-range grant is still accepted but never reaches the array.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    acc_oor = 1'b0;
    if (f_gnt) begin
      m_addr  = f_addr;
      acc_oor = f_oor;
      m_en    = !f_oor;
    end else if (l_gnt) begin
      m_addr  = l_addr;
      m_we    = l_we;
      acc_oor = l_oor;
      m_en    = !l_oor;
    end
  end

  assign m_wdata = rst_n ? l_wdata : '0;

  always_comb begin
    resp_d           = RESP_IDLE;
    resp_d.owner     = f_gnt ? OWN_FETCH : OWN_LOADER;
    resp_d.was_write = l_gnt & l_we;
    resp_d.oor       = acc_oor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_q       <= RESP_IDLE;
    end else begin
      resp_valid_q <= f_gnt | l_gnt;
      resp_q       <= resp_d;
    end
  end

  assign f_rvalid  = resp_valid_q && (resp_q.owner == OWN_FETCH);
  assign l_rvalid  = resp_valid_q && (resp_q.owner == OWN_LOADER);
  assign f_err     = f_rvalid & resp_q.oor;
  assign l_err     = l_rvalid & resp_q.oor;
  assign resp_data = (resp_q.was_write || resp_q.oor) ? '0 : m_rdata;

  // Read data is passed straight through in the response cycle and held
  // afterwards, so rdata stays stable until that requester's next response.
  assign f_rdata = f_rvalid ? resp_data : f_rdata_q;
  assign l_rdata = l_rvalid ? resp_data : l_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the rdata holding registers are reset explicitly; they are plain
    // flops, not a memory array, and must read 0 straight out of reset.
    if (!rst_n) begin
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      if (f_rvalid) f_rdata_q <= resp_data;
      if (l_rvalid) l_rdata_q <= resp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_stall_cnt <= '0;
    end else if (f_req && !f_gnt && (f_stall_cnt != '1)) begin
      f_stall_cnt <= f_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a behavioural 1-cycle memory sits behind
// the arbiter and a separate golden copy supplies every expected data word.
module tb_imem_arbiter;

  localparam int AW = 64;
  localparam int DW = 80;
  localparam int DEPTH = 10;
  localparam logic [DW-1:0] INIT_BASE = 80'hD00D_0000_0000_0000_0000;
  localparam logic [DW-1:0] LOAD_BASE = 80'h0123_4567_89AB_CDEF_00A0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req, l_req, l_we, l_lock;
  logic [AW-1:0] f_addr, l_addr;
  logic [DW-1:0] l_wdata;
  logic          f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err;
  logic [DW-1:0] f_rdata, l_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic [31:0]   f_stall_cnt;

  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] gold [DEPTH];

  int n_cmp = 0;
  int n_err = 0;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .f_stall_cnt(f_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en && (m_addr < 64'(DEPTH))) begin
      if (m_we) mem[m_addr[3:0]] <= m_wdata;
      m_rdata <= mem[m_addr[3:0]];
    end
  end

  task automatic idle_inputs();
    f_req = 1'b0; f_addr = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; l_lock = 1'b0;
  endtask

  // Leaves the bench 1 ns after a rising edge with the DUT idle and fresh.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    f_req = 1'b1;
    f_addr = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (f_gnt !== 1'b0) begin n_err++; $display("FAIL rst_f_gnt: got %b want 0", f_gnt); end
    n_cmp++; if (m_en !== 1'b0) begin n_err++; $display("FAIL rst_m_en: got %b want 0", m_en); end
    n_cmp++; if (m_addr !== '0) begin n_err++; $display("FAIL rst_m_addr: got %h want 0", m_addr); end
    n_cmp++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_f_rvalid: got %b want 0", f_rvalid); end
    n_cmp++; if (f_stall_cnt !== 32'd0) begin n_err++; $display("FAIL rst_stall: got %0d want 0", f_stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL first_f_gnt: got %b want 1", f_gnt); end
    n_cmp++; if (m_en !== 1'b1) begin n_err++; $display("FAIL first_m_en: got %b want 1", m_en); end
    n_cmp++; if (m_we !== 1'b0) begin n_err++; $display("FAIL first_m_we: got %b want 0", m_we); end
    @(posedge clk);
    #1;
    n_cmp++; if (f_rvalid !== 1'b1) begin n_err++; $display("FAIL first_f_rvalid: got %b want 1", f_rvalid); end
    n_cmp++; if (f_rdata !== gold[0]) begin n_err++; $display("FAIL first_f_rdata: got %h want %h", f_rdata, gold[0]); end
    n_cmp++; if (f_err !== 1'b0) begin n_err++; $display("FAIL first_f_err: got %b want 0", f_err); end
    n_cmp++; if (f_stall_cnt !== 32'd0) begin n_err++; $display("FAIL first_stall: got %0d want 0", f_stall_cnt); end
    f_req = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL first_rvalid_drop: got %b want 0", f_rvalid); end
  endtask

  task automatic test_round_robin();
    logic fexp;
    logic [DW-1:0] dexp;
    do_reset();
    f_req = 1'b1; f_addr = 64'd1;
    l_req = 1'b1; l_addr = 64'd2; l_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fexp = (k % 2 == 0);
      dexp = fexp ? gold[1] : gold[2];
      #1;
      n_cmp++; if (f_gnt !== fexp) begin n_err++; $display("FAIL rr_f_gnt[%0d]: got %b want %b", k, f_gnt, fexp); end
      n_cmp++; if (l_gnt !== !fexp) begin n_err++; $display("FAIL rr_l_gnt[%0d]: got %b want %b", k, l_gnt, !fexp); end
      n_cmp++; if (m_addr !== (fexp ? 64'd1 : 64'd2)) begin n_err++; $display("FAIL rr_m_addr[%0d]: got %h", k, m_addr); end
      @(posedge clk);
      #1;
      n_cmp++; if (f_rvalid !== fexp || l_rvalid !== !fexp) begin
        n_err++; $display("FAIL rr_rvalid[%0d]: got f=%b l=%b want f=%b", k, f_rvalid, l_rvalid, fexp);
      end
      n_cmp++; if ((fexp ? f_rdata : l_rdata) !== dexp) begin
        n_err++; $display("FAIL rr_rdata[%0d]: got f=%h l=%h want %h", k, f_rdata, l_rdata, dexp);
      end
    end
    idle_inputs();
    n_cmp++; if (f_stall_cnt !== 32'd2) begin n_err++; $display("FAIL rr_stall: got %0d want 2", f_stall_cnt); end
  endtask

  task automatic test_lock_load();
    logic [DW-1:0] wd;
    do_reset();
    l_lock = 1'b1;
    f_req = 1'b1; f_addr = 64'd5;
    l_req = 1'b1; l_we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wd = LOAD_BASE + DW'(i);
      l_addr = 64'(i);
      l_wdata = wd;
      #1;
      n_cmp++; if (f_gnt !== 1'b0 || l_gnt !== 1'b1) begin
        n_err++; $display("FAIL lock_gnt[%0d]: got f=%b l=%b want f=0 l=1", i, f_gnt, l_gnt);
      end
      n_cmp++; if (m_en !== 1'b1 || m_we !== 1'b1 || m_addr !== 64'(i) || m_wdata !== wd) begin
        n_err++; $display("FAIL lock_mem[%0d]: got en=%b we=%b a=%h d=%h want d=%h", i, m_en, m_we, m_addr, m_wdata, wd);
      end
      @(posedge clk);
      #1;
      gold[i] = wd;
      n_cmp++; if (l_rvalid !== 1'b1 || l_err !== 1'b0 || l_rdata !== '0) begin
        n_err++; $display("FAIL lock_ack[%0d]: got v=%b e=%b d=%h want v=1 e=0 d=0", i, l_rvalid, l_err, l_rdata);
      end
    end
    l_req = 1'b0; l_we = 1'b0;
    n_cmp++; if (f_stall_cnt !== 32'd10) begin n_err++; $display("FAIL lock_stall: got %0d want 10", f_stall_cnt); end
    l_lock = 1'b0;
    f_addr = 64'd3;
    #1;
    n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL unlock_f_gnt: got %b want 1", f_gnt); end
    @(posedge clk);
    #1;
    n_cmp++; if (f_rvalid !== 1'b1 || f_rdata !== LOAD_BASE + 80'd3) begin
      n_err++; $display("FAIL unlock_f_rdata: got v=%b d=%h want %h", f_rvalid, f_rdata, LOAD_BASE + 80'd3);
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    do_reset();
    l_req = 1'b1; l_we = 1'b0; l_addr = 64'd4;
    @(posedge clk);
    #1;
    n_cmp++; if (l_rdata !== gold[4]) begin n_err++; $display("FAIL oor_pre_rdata: got %h want %h", l_rdata, gold[4]); end
    l_addr = 64'd10;
    #1;
    n_cmp++; if (l_gnt !== 1'b1 || m_en !== 1'b0) begin
      n_err++; $display("FAIL oor_l_grant: got gnt=%b m_en=%b want gnt=1 m_en=0", l_gnt, m_en);
    end
    @(posedge clk);
    #1;
    n_cmp++; if (l_rvalid !== 1'b1 || l_err !== 1'b1 || l_rdata !== '0) begin
      n_err++; $display("FAIL oor_l_resp: got v=%b e=%b d=%h want v=1 e=1 d=0", l_rvalid, l_err, l_rdata);
    end
    l_req = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (l_rvalid !== 1'b0 || l_err !== 1'b0 || l_rdata !== '0) begin
      n_err++; $display("FAIL oor_l_after: got v=%b e=%b d=%h want v=0 e=0 d=0", l_rvalid, l_err, l_rdata);
    end
    f_req = 1'b1; f_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    n_cmp++; if (f_gnt !== 1'b1 || m_en !== 1'b0) begin
      n_err++; $display("FAIL oor_f_grant: got gnt=%b m_en=%b want gnt=1 m_en=0", f_gnt, m_en);
    end
    @(posedge clk);
    #1;
    n_cmp++; if (f_rvalid !== 1'b1 || f_err !== 1'b1 || f_rdata !== '0) begin
      n_err++; $display("FAIL oor_f_resp: got v=%b e=%b d=%h want v=1 e=1 d=0", f_rvalid, f_err, f_rdata);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    f_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_addr = 64'(i);
      #1;
      n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, f_gnt); end
      @(posedge clk);
      #1;
      n_cmp++; if (f_rvalid !== 1'b1 || f_rdata !== gold[i]) begin
        n_err++; $display("FAIL b2b_resp[%0d]: got v=%b d=%h want v=1 d=%h", i, f_rvalid, f_rdata, gold[i]);
      end
    end
    f_req = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (f_rvalid !== 1'b0 || f_rdata !== gold[2]) begin
      n_err++; $display("FAIL b2b_hold: got v=%b d=%h want v=0 d=%h", f_rvalid, f_rdata, gold[2]);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    f_req = 1'b1; f_addr = 64'd7;
    #1;
    n_cmp++; if (f_gnt !== 1'b1) begin n_err++; $display("FAIL mid_gnt: got %b want 1", f_gnt); end
    @(posedge clk);
    #1;
    f_req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (f_rvalid !== 1'b0 || f_rdata !== '0 || f_err !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_resp: got v=%b e=%b d=%h want all 0", f_rvalid, f_err, f_rdata);
    end
    n_cmp++; if (m_en !== 1'b0 || m_we !== 1'b0 || m_addr !== '0 || m_wdata !== '0 || f_gnt !== 1'b0 || l_gnt !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_mem: got en=%b we=%b a=%h fg=%b lg=%b want all 0", m_en, m_we, m_addr, f_gnt, l_gnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin
        n_err++; $display("FAIL mid_no_resp[%0d]: got f=%b l=%b want 0", k, f_rvalid, l_rvalid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      gold[i] = INIT_BASE + DW'(i);
      mem[i]  = INIT_BASE + DW'(i);
    end
    test_reset();
    test_round_robin();
    test_lock_load();
    test_out_of_range();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
